// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780-compatible LCD receiver.
// Holds command opcodes (each opcode is also the single bit that selects it
// in the priority decode), display geometry constants, the receive FSM state
// type and DDRAM address stepping helpers.
package lcd_pkg;

    // Command opcodes; the highest set bit of a command byte selects it.
    localparam logic [7:0] CMD_CLR   = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_DISP  = 8'h08;
    localparam logic [7:0] CMD_SHIFT = 8'h10;
    localparam logic [7:0] CMD_FUNC  = 8'h20;
    localparam logic [7:0] CMD_CGRAM = 8'h40;
    localparam logic [7:0] CMD_DDRAM = 8'h80;

    // Option bits inside the commands above.
    localparam logic [7:0] ENTRY_ID  = 8'h02;   // 1 = increment
    localparam logic [7:0] DISP_D    = 8'h04;   // display on
    localparam logic [7:0] FUNC_DL   = 8'h10;   // 1 = 8-bit interface

    localparam logic [7:0] SPACE      = 8'h20;
    localparam int         LINE_LEN   = 16;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE_END   = 7'h27;
    localparam logic [6:0] ADDR_LAST  = LINE2_BASE + LINE_END;   // 0x67

    typedef enum logic [1:0] {
        S_8BIT    = 2'd0,
        S_4BIT_HI = 2'd1,
        S_4BIT_LO = 2'd2
    } lcd_state_e;

    // Address counter step with the two-line wrap points of the controller.
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic incr);
        logic [6:0] r;
        if (incr) begin
            if (a == LINE_END)       r = LINE2_BASE;
            else if (a == ADDR_LAST) r = 7'h00;
            else                     r = a + 7'd1;
        end else begin
            if (a == 7'h00)          r = ADDR_LAST;
            else if (a == LINE2_BASE) r = LINE_END;
            else                     r = a - 7'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_capture_in_sync.sv
// lcd_capture_in_sync: synchronizes the asynchronous LCD bus into clk,
// detects the falling edge of E and holds the bus value sampled while E was
// high, so the strobe carries the data present before E dropped.
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   lcd_e_i/rs_i/rw_i   raw LCD control inputs
//   lcd_d_i[3:0]        raw data nibble (bit 3 = lcd_7)
//   fall_o              high for one cycle after E falls
//   rs_o, rw_o, nib_o   bus value captured during the E-high phase
module lcd_capture_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       lcd_e_i,
    input  logic       lcd_rs_i,
    input  logic       lcd_rw_i,
    input  logic [3:0] lcd_d_i,
    output logic       fall_o,
    output logic       rs_o,
    output logic       rw_o,
    output logic [3:0] nib_o
);

    // Fewer than two stages is not a synchronizer.
    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    // Bus packed as {e, rs, rw, d[3:0]}.
    logic [6:0] sync_q [NS];
    logic       e_d_q;
    logic [5:0] cap_q;
    logic       e_sync;

    assign e_sync = sync_q[NS-1][6];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NS; i++) sync_q[i] <= '0;
            e_d_q <= 1'b0;
            cap_q <= '0;
        end else begin
            sync_q[0] <= {lcd_e_i, lcd_rs_i, lcd_rw_i, lcd_d_i};
            for (int i = 1; i < NS; i++) sync_q[i] <= sync_q[i-1];
            e_d_q <= e_sync;
            if (e_sync) cap_q <= sync_q[NS-1][5:0];
        end
    end

    assign fall_o = e_d_q & ~e_sync;
    assign rs_o   = cap_q[5];
    assign rw_o   = cap_q[4];
    assign nib_o  = cap_q[3:0];

endmodule

// File: rtl/lcd_capture.sv
// lcd_capture: passive HD44780-compatible display-side receiver. Decodes
// 8-bit or 4-bit bus strobes into bytes, executes commands and keeps a
// shadow of the two visible 16-character lines.
// Ports:
//   clk, rst                 clock, async active-high reset
//   lcd_rs, lcd_rw, lcd_e    LCD control (rw = 1 strobes are ignored)
//   lcd_4..lcd_7             data nibble, lcd_7 = MSB
//   chars[255:0]             line 1 in [255:128], line 2 in [127:0], col 0 at MSB byte
//   byte_valid/data/rs       one-cycle pulse per decoded byte with its value and rs
//   ddram_addr[6:0]          address counter
//   four_bit, display_on     interface mode and display D bit
//   nib_timeout              pulse when a lone high nibble is discarded
module lcd_capture
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NIB_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic         lcd_e,
    input  logic         lcd_4,
    input  logic         lcd_5,
    input  logic         lcd_6,
    input  logic         lcd_7,
    output logic [255:0] chars,
    output logic         byte_valid,
    output logic [7:0]   byte_data,
    output logic         byte_rs,
    output logic [6:0]   ddram_addr,
    output logic         four_bit,
    output logic         display_on,
    output logic         nib_timeout
);

    localparam logic [31:0] TMO_LAST = (NIB_TIMEOUT > 0) ? 32'(NIB_TIMEOUT - 1) : 32'd0;

    logic       fall, cap_rs, cap_rw;
    logic [3:0] cap_nib;

    lcd_capture_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_in_sync (
        .clk_i    (clk),
        .rst_i    (rst),
        .lcd_e_i  (lcd_e),
        .lcd_rs_i (lcd_rs),
        .lcd_rw_i (lcd_rw),
        .lcd_d_i  ({lcd_7, lcd_6, lcd_5, lcd_4}),
        .fall_o   (fall),
        .rs_o     (cap_rs),
        .rw_o     (cap_rw),
        .nib_o    (cap_nib)
    );

    lcd_state_e  state_q;
    logic [255:0] chars_q;
    logic         byte_valid_q, byte_rs_q, four_bit_q, display_on_q, nib_timeout_q;
    logic [7:0]   byte_data_q;
    logic [6:0]   ddram_addr_q;
    logic         incr_q, cgram_sel_q, hi_rs_q;
    logic [3:0]   hi_nib_q;
    logic [31:0]  tmo_cnt_q;

    logic         strobe, byte_ev, ev_rs, wr_hit;
    logic [7:0]   ev_byte, wr_lsb;
    logic [6:0]   addr_d;

    // Assemble a complete byte from the current strobe and FSM phase.
    always_comb begin
        strobe  = fall & ~cap_rw;
        byte_ev = 1'b0;
        ev_byte = 8'h00;
        ev_rs   = 1'b0;
        case (state_q)
            S_8BIT: begin
                byte_ev = strobe;
                ev_byte = {cap_nib, 4'h0};
                ev_rs   = cap_rs;
            end
            S_4BIT_LO: begin
                byte_ev = strobe;
                ev_byte = {hi_nib_q, cap_nib};
                ev_rs   = hi_rs_q;
            end
            default: ;
        endcase
    end

    // Visible cells: 0x00-0x0F on line 1, 0x40-0x4F on line 2.
    assign wr_hit = (ddram_addr_q < 7'(LINE_LEN)) ||
                    ((ddram_addr_q >= LINE2_BASE) && (ddram_addr_q < LINE2_BASE + 7'(LINE_LEN)));
    assign wr_lsb = (ddram_addr_q[6] ? 8'd120 : 8'd248) - {1'b0, ddram_addr_q[3:0], 3'b000};
    assign addr_d = addr_step(ddram_addr_q, incr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_8BIT;
            chars_q       <= {32{SPACE}};
            byte_valid_q  <= 1'b0;
            byte_data_q   <= 8'h00;
            byte_rs_q     <= 1'b0;
            ddram_addr_q  <= 7'h00;
            four_bit_q    <= 1'b0;
            display_on_q  <= 1'b0;
            nib_timeout_q <= 1'b0;
            incr_q        <= 1'b1;
            cgram_sel_q   <= 1'b0;
            hi_rs_q       <= 1'b0;
            hi_nib_q      <= 4'h0;
            tmo_cnt_q     <= '0;
        end else begin
            byte_valid_q  <= byte_ev;
            nib_timeout_q <= 1'b0;
            if (byte_ev) begin
                byte_data_q <= ev_byte;
                byte_rs_q   <= ev_rs;
            end

            case (state_q)
                S_4BIT_HI: if (strobe) begin
                    hi_nib_q  <= cap_nib;
                    hi_rs_q   <= cap_rs;
                    tmo_cnt_q <= '0;
                    state_q   <= S_4BIT_LO;
                end
                S_4BIT_LO: begin
                    if (strobe) begin
                        state_q <= S_4BIT_HI;
                    end else if ((NIB_TIMEOUT > 0) && (tmo_cnt_q == TMO_LAST)) begin
                        // Lone high nibble: drop it and realign on the next strobe.
                        nib_timeout_q <= 1'b1;
                        state_q       <= S_4BIT_HI;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    end
                end
                default: ;
            endcase

            // Byte execution; a function-set here overrides the phase step above.
            if (byte_ev) begin
                if (!ev_rs) begin
                    if ((ev_byte & CMD_DDRAM) != 8'h00) begin
                        ddram_addr_q <= ev_byte[6:0];
                        cgram_sel_q  <= 1'b0;
                    end else if ((ev_byte & CMD_CGRAM) != 8'h00) begin
                        cgram_sel_q <= 1'b1;
                    end else if ((ev_byte & CMD_FUNC) != 8'h00) begin
                        if ((ev_byte & FUNC_DL) != 8'h00) begin
                            four_bit_q <= 1'b0;
                            state_q    <= S_8BIT;
                        end else begin
                            four_bit_q <= 1'b1;
                            state_q    <= S_4BIT_HI;
                        end
                    end else if ((ev_byte & CMD_SHIFT) != 8'h00) begin
                        // Cursor/display shift does not affect the shadow.
                    end else if ((ev_byte & CMD_DISP) != 8'h00) begin
                        display_on_q <= (ev_byte & DISP_D) != 8'h00;
                    end else if ((ev_byte & CMD_ENTRY) != 8'h00) begin
                        incr_q <= (ev_byte & ENTRY_ID) != 8'h00;
                    end else if ((ev_byte & CMD_HOME) != 8'h00) begin
                        ddram_addr_q <= 7'h00;
                    end else if ((ev_byte & CMD_CLR) != 8'h00) begin
                        chars_q      <= {32{SPACE}};
                        ddram_addr_q <= 7'h00;
                        incr_q       <= 1'b1;
                    end
                end else if (!cgram_sel_q) begin
                    if (wr_hit) chars_q[wr_lsb +: 8] <= ev_byte;
                    ddram_addr_q <= addr_d;
                end
            end
        end
    end

    assign chars       = chars_q;
    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign byte_rs     = byte_rs_q;
    assign ddram_addr  = ddram_addr_q;
    assign four_bit    = four_bit_q;
    assign display_on  = display_on_q;
    assign nib_timeout = nib_timeout_q;

endmodule

// File: doc/lcd_capture.md
Name: lcd_capture

Overview:
- Passive HD44780-compatible receiver (display-side model) for the 4-bit LCD bus driven by the team's LCD writer: monitors lcd_rs/lcd_rw/lcd_e/lcd_4..lcd_7 and decodes nibbles into commands and data.
- Keeps a shadow of the two 16-character visible lines, in the same 256-bit chars layout the writer consumes.
- Used on-board to mirror/verify display content and in benches as the checker-side endpoint of the LCD interface.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on every LCD input (min 2).
- NIB_TIMEOUT, 0, clk cycles allowed between high and low nibble before phase resyncs to high; 0 disables.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-high reset.
- lcd_rs  input  1  register select (0 cmd, 1 data).
- lcd_rw  input  1  read/write (1 = read strobe, ignored).
- lcd_e  input  1  enable strobe; data latched on falling edge.
- lcd_4..lcd_7  input  1 each  data nibble, lcd_7 = MSB.
- chars  output  256  line 1 in [255:128], line 2 in [127:0]; column 0 in the MSB byte of each line.
- byte_valid  output  1  one-cycle pulse per decoded byte.
- byte_data  output  8  decoded byte, valid with byte_valid.
- byte_rs  output  1  rs of that byte.
- ddram_addr  output  7  current address counter.
- four_bit  output  1  interface in 4-bit mode.
- display_on  output  1  D bit of last display-control cmd.
- nib_timeout  output  1  one-cycle pulse when a half byte is discarded.

Behaviour:
- Reset values: chars = all 0x20, byte_valid 0, byte_data 0x00, byte_rs 0, ddram_addr 0, four_bit 0, display_on 0, nib_timeout 0. Internal: incr = 1, cgram_sel 0, state S_8BIT.
- Inputs pass through SYNC_STAGES flops. Edge register e_d detects fall = e_d & ~e_sync.
- While e_sync = 1, capture {rs, rw, d7..d4} every cycle. Fall uses the last captured value. E high must last ≥ 2 clk.
- Latency: clk edge k first samples lcd_e = 0 (SYNC_STAGES = 2). byte_valid, byte_data and all state updates are registered at edge k+2.
- Strobes with rw = 1 are ignored: no phase change, no output.
- FSM:
  - S_8BIT: each strobe yields byte {nibble, 4'h0}, processed immediately. A function-set with DL = 0 sets four_bit = 1 and goes to S_4BIT_HI.
  - S_4BIT_HI: store high nibble and rs, go to S_4BIT_LO.
  - S_4BIT_LO: byte = {hi, lo}. rs is taken from the high strobe. Process byte, go to S_4BIT_HI.
  - Function-set with DL = 1 returns to S_8BIT, four_bit = 0.
- Timeout: if NIB_TIMEOUT > 0 and S_4BIT_LO lasts NIB_TIMEOUT cycles with no strobe, pulse nib_timeout, go to S_4BIT_HI, no byte produced.
- Command decode, priority by highest set bit:
  - 0x01 clear: chars all 0x20, addr 0, incr 1.
  - 0x02/03: addr 0.
  - 0x04-07: incr = bit1.
  - 0x08-0F: display_on = bit2.
  - 0x10-1F: ignored.
  - 0x20-3F: DL = bit4.
  - 0x40-7F: cgram_sel = 1.
  - 0x80-FF: addr = byte[6:0], cgram_sel = 0.
- Data (rs = 1):
  - If cgram_sel: discard, no addr change.
  - Else write byte at addr. 0x00-0x0F maps to line 1 col addr; 0x40-0x4F maps to line 2 col addr-0x40; other addresses are not stored.
  - Then addr ± 1. Increment wraps 0x27→0x40 and 0x67→0x00; decrement wraps 0x00→0x67 and 0x40→0x27.
- byte_valid pulses for every decoded byte, command or data, including discarded ones.
- Clear and a write never coincide: one byte per event.
- rst mid-byte: immediate return to reset values; half nibble lost.

Decomposition:
- Package lcd_pkg holds:
  - command masks/opcodes (CLR, HOME, ENTRY, DISP, SHIFT, FUNC, CGRAM, DDRAM);
  - SPACE = 8'h20, LINE_LEN = 16, LINE2_BASE = 7'h40, LINE_END = 7'h27;
  - FSM state enum.
- One sub-module, lcd_in_sync: parameterized synchronizer + fall detect + capture register. Outputs fall, rs, rw and nibble.

Test Plan:
- Reset asserted mid-run → chars = 256'h2020…20, four_bit 0, ddram_addr 0, byte_valid 0.
- 8-bit init strobes 3,3,3,2 (rs 0) → four byte_valid pulses with 0x30, 0x30, 0x30, 0x20. four_bit = 1 after the 4th; each pulse at edge k+2.
- 4-bit cmds 0x28, 0x0C, 0x06, 0x01, then data 0x41 → display_on 1, chars[255:248] = 0x41, remaining chars 0x20, ddram_addr 0x01.
- Cmd 0xC0, then " 11 - 10 - 2023 " as data → chars[127:0] equals that string, ddram_addr 0x50.
- Cmd 0xA7, data 'x' → addr 0x40, chars unchanged. Cmd 0xE7, data 'y' → addr 0x00, chars unchanged. Cmd 0x04, data 'z' at 0x00 → chars[255:248] = 'z', addr 0x67.
- rw = 1 strobe between nibbles → no effect, next strobe completes the byte. NIB_TIMEOUT = 100 with a lone high nibble → nib_timeout pulse at cycle 100, next two strobes form a correct byte.
